// File: rtl/icache_fetcher.sv
// Instruction fetcher with a small direct-mapped instruction cache.
// Hits return the cached word one cycle after FETCH; misses issue a single
// program-memory read, hold it until the response strobe, then fill the line.
module icache_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int INDEX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCHING = 3'd1,
        ST_FETCHED  = 3'd2
    } fetch_state_e;

    fetch_state_e state, state_next;

    logic [CACHE_LINES-1:0]           line_valid;
    logic [TAG_BITS-1:0]              line_tag  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_LINES];

    logic [INDEX_BITS-1:0] lookup_index;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic                  lookup_hit;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;

    logic fetch_seen;
    logic hit_event;
    logic miss_event;
    logic fill_event;

    // Cache lookup on the live PC; fill side uses the latched request address
    always_comb begin
        lookup_index = current_pc[INDEX_BITS-1:0];
        lookup_tag   = current_pc[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];
        lookup_hit   = line_valid[lookup_index] && (line_tag[lookup_index] == lookup_tag);
        fill_index   = mem_read_address[INDEX_BITS-1:0];
        fill_tag     = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];
        fetch_seen   = (state == ST_IDLE) && (core_state == CORE_FETCH);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (fetch_seen) begin
                    state_next = (lookup_hit && !flush) ? ST_FETCHED : ST_FETCHING;
                end
            end
            ST_FETCHING: begin
                if (mem_read_ready) begin
                    state_next = ST_FETCHED;
                end
            end
            ST_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/event decode driving the registered datapath below
    always_comb begin
        hit_event  = fetch_seen && lookup_hit && !flush;
        miss_event = fetch_seen && !(lookup_hit && !flush);
        fill_event = (state == ST_FETCHING) && mem_read_ready;
        fetcher_state = state;
    end

    // Memory request, delivered instruction, valid bits and statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            line_valid       <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            if (miss_event) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= current_pc;
                if (miss_count != '1) begin
                    miss_count <= miss_count + 16'd1;
                end
            end else if (fill_event) begin
                mem_read_valid <= 1'b0;
            end

            if (hit_event) begin
                instruction <= line_data[lookup_index];
                if (hit_count != '1) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else if (fill_event) begin
                instruction <= mem_read_data;
            end

            // A flush landing on the fill cycle wins: data is delivered but the line stays invalid
            if (flush) begin
                line_valid <= '0;
            end else if (fill_event) begin
                line_valid[fill_index] <= 1'b1;
            end
        end
    end

    // Line tag/data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_event) begin
            line_tag[fill_index]  <= fill_tag;
            line_data[fill_index] <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher: miss/hit flow, line replacement,
// flush interactions, asynchronous reset mid-request and counter saturation.
module tb_icache_fetcher;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] C_IDLE = 3'd0, C_FETCH = 3'd1, C_DECODE = 3'd2, C_WAIT = 3'd4;
    localparam logic [2:0] F_IDLE = 3'd0, F_FETCHING = 3'd1, F_FETCHED = 3'd2;

    icache_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .CACHE_LINES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .core_state(core_state),
        .current_pc(current_pc),
        .flush(flush),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present FETCH for one cycle, then move the core to WAIT
    task automatic fetch(input logic [7:0] pc, input logic fl);
        core_state = C_FETCH;
        current_pc = pc;
        flush      = fl;
        step();
        core_state = C_WAIT;
        flush      = 1'b0;
    endtask

    // Memory response strobe for one cycle
    task automatic respond(input logic [15:0] d, input logic fl);
        mem_read_ready = 1'b1;
        mem_read_data  = d;
        flush          = fl;
        step();
        mem_read_ready = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic decode();
        core_state = C_DECODE;
        step();
        core_state = C_IDLE;
    endtask

    initial begin
        reset_n        = 1'b0;
        core_state     = C_IDLE;
        current_pc     = 8'h00;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        step();
        step();
        chk("rst_state", fetcher_state, F_IDLE);
        chk("rst_valid", mem_read_valid, 1'b0);
        chk("rst_addr", mem_read_address, 8'h00);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_hits", hit_count, 16'd0);
        chk("rst_miss", miss_count, 16'd0);
        reset_n = 1'b1;
        step();
        chk("idle_noop", fetcher_state, F_IDLE);

        // Cold miss on 0x05, memory answers after three request cycles
        fetch(8'h05, 1'b0);
        chk("miss1_state", fetcher_state, F_FETCHING);
        chk("miss1_valid_c1", mem_read_valid, 1'b1);
        chk("miss1_addr", mem_read_address, 8'h05);
        chk("miss1_count", miss_count, 16'd1);
        current_pc = 8'hAA;
        step();
        chk("miss1_valid_c2", mem_read_valid, 1'b1);
        chk("miss1_addr_hold", mem_read_address, 8'h05);
        step();
        chk("miss1_valid_c3", mem_read_valid, 1'b1);
        respond(16'h1234, 1'b0);
        chk("fill1_valid", mem_read_valid, 1'b0);
        chk("fill1_state", fetcher_state, F_FETCHED);
        chk("fill1_instr", instruction, 16'h1234);
        core_state = 3'd3;
        step();
        chk("fetched_hold", fetcher_state, F_FETCHED);
        decode();
        chk("decode_idle", fetcher_state, F_IDLE);
        chk("decode_instr", instruction, 16'h1234);

        // Hit on 0x05
        fetch(8'h05, 1'b0);
        chk("hit1_state", fetcher_state, F_FETCHED);
        chk("hit1_instr", instruction, 16'h1234);
        chk("hit1_valid", mem_read_valid, 1'b0);
        chk("hit1_count", hit_count, 16'd1);
        chk("hit1_miss", miss_count, 16'd1);
        decode();

        // 0x09 shares index 1 with a different tag: replace, then 0x05 misses
        fetch(8'h09, 1'b0);
        chk("conf_state", fetcher_state, F_FETCHING);
        chk("conf_addr", mem_read_address, 8'h09);
        chk("conf_miss", miss_count, 16'd2);
        respond(16'hBEEF, 1'b0);
        chk("conf_instr", instruction, 16'hBEEF);
        decode();
        fetch(8'h05, 1'b0);
        chk("evict_state", fetcher_state, F_FETCHING);
        chk("evict_miss", miss_count, 16'd3);
        respond(16'h1234, 1'b0);
        chk("evict_instr", instruction, 16'h1234);
        decode();

        // Stray response strobe while idle is ignored
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5555;
        step();
        mem_read_ready = 1'b0;
        chk("stray_state", fetcher_state, F_IDLE);
        chk("stray_instr", instruction, 16'h1234);

        // Flush coincident with fill: data delivered, line stays invalid
        fetch(8'h02, 1'b0);
        chk("fl_miss", miss_count, 16'd4);
        respond(16'h00AA, 1'b1);
        chk("fl_state", fetcher_state, F_FETCHED);
        chk("fl_instr", instruction, 16'h00AA);
        decode();
        fetch(8'h02, 1'b0);
        chk("fl_remiss_state", fetcher_state, F_FETCHING);
        chk("fl_remiss_count", miss_count, 16'd5);
        respond(16'h00AA, 1'b0);
        decode();
        fetch(8'h02, 1'b0);
        chk("fl_hit_state", fetcher_state, F_FETCHED);
        chk("fl_hit_count", hit_count, 16'd2);
        decode();

        // Flush while idle invalidates 0x05
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch(8'h05, 1'b0);
        chk("idleflush_state", fetcher_state, F_FETCHING);
        chk("idleflush_miss", miss_count, 16'd6);
        respond(16'h1234, 1'b0);
        decode();

        // Flush in the FETCH cycle forces a miss on a valid line
        fetch(8'h05, 1'b1);
        chk("fetchflush_state", fetcher_state, F_FETCHING);
        chk("fetchflush_miss", miss_count, 16'd7);
        chk("fetchflush_hits", hit_count, 16'd2);
        respond(16'h1234, 1'b0);
        decode();

        // Asynchronous reset while a request is outstanding
        fetch(8'h07, 1'b0);
        chk("pre_rst_state", fetcher_state, F_FETCHING);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state", fetcher_state, F_IDLE);
        chk("arst_valid", mem_read_valid, 1'b0);
        chk("arst_miss", miss_count, 16'd0);
        chk("arst_hits", hit_count, 16'd0);
        chk("arst_instr", instruction, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fetch(8'h05, 1'b0);
        chk("post_rst_state", fetcher_state, F_FETCHING);
        chk("post_rst_miss", miss_count, 16'd1);
        respond(16'h1234, 1'b0);
        decode();

        // Miss counter saturation
        force dut.miss_count = 16'hFFFE;
        #1;
        release dut.miss_count;
        fetch(8'h0D, 1'b0);
        chk("sat1_miss", miss_count, 16'hFFFF);
        respond(16'h0D0D, 1'b0);
        chk("sat1_instr", instruction, 16'h0D0D);
        decode();
        fetch(8'h05, 1'b0);
        chk("sat2_state", fetcher_state, F_FETCHING);
        chk("sat2_miss", miss_count, 16'hFFFF);
        respond(16'h1234, 1'b0);
        decode();
        chk("sat_hold", miss_count, 16'hFFFF);
        chk("sat_hits", hit_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_fetcher.md
ICACHE_FETCHER -- requirements
Module: icache_fetcher

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8, program memory address width (equals PC width).
REQ-002 Parameter PROGRAM_MEM_DATA_BITS, default 16, instruction width.
REQ-003 Parameter CACHE_LINES, default 4, number of direct-mapped lines; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 core_state  input  3  scheduler state: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
REQ-007 current_pc  input  PROGRAM_MEM_ADDR_BITS  address of the instruction to fetch.
REQ-008 flush  input  1  invalidate all cache lines.
REQ-009 mem_read_valid  output  1  program memory read request.
REQ-010 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address.
REQ-011 mem_read_ready  input  1  memory response strobe; data valid this cycle.
REQ-012 mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction.
REQ-013 fetcher_state  output  3  IDLE=0, FETCHING=1, FETCHED=2; other codes never driven.
REQ-014 instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction; stable while fetcher_state=FETCHED.
REQ-015 hit_count, miss_count  output  16 each  saturating lookup statistics.

Function
REQ-016 Index = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper PC bits; each line holds valid bit, tag, data.
REQ-017 IDLE with core_state=FETCH, flush=0, valid line with matching tag (hit): next cycle instruction=line data, fetcher_state=FETCHED, hit_count+1; no memory request issued.
REQ-018 IDLE with core_state=FETCH and miss (or flush=1 same cycle): next cycle fetcher_state=FETCHING, mem_read_valid=1, mem_read_address=current_pc, miss_count+1.
REQ-019 FETCHING: mem_read_valid and mem_read_address held constant until the cycle mem_read_ready=1.
REQ-020 FETCHING with mem_read_ready=1: next cycle mem_read_valid=0, instruction=mem_read_data, line[index] written (valid=1, tag, data), fetcher_state=FETCHED.
REQ-021 Miss latency: FETCHED no earlier than 2 cycles after FETCH seen; hit latency exactly 1 cycle.
REQ-022 FETCHED: remain until core_state=DECODE, then next cycle fetcher_state=IDLE; instruction retained.
REQ-023 IDLE with core_state other than FETCH: no action, outputs hold.
REQ-024 flush=1 clears all valid bits next cycle in any state; does not abort an outstanding memory request.
REQ-025 flush=1 in the same cycle as a fill (mem_read_ready=1): instruction still delivered, line NOT marked valid.
REQ-026 mem_read_ready=1 outside FETCHING is ignored.
REQ-027 Counters saturate at 16'hFFFF, never wrap.
REQ-028 current_pc sampled only in IDLE; changes during FETCHING/FETCHED are ignored.

Reset
REQ-029 reset_n=0 asynchronously forces: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, all valid bits=0, hit_count=0, miss_count=0.
REQ-030 Reset mid-FETCHING drops the request immediately; no line is written; first fetch after reset is a miss.
REQ-031 Operation resumes on the first rising clk edge with reset_n=1.

Verification
REQ-032 After reset, core_state=FETCH, pc=0x05, ready after 3 cycles with data 0x1234 -> mem_read_valid high 3 cycles, address 0x05, FETCHED with instruction 0x1234, miss_count=1.
REQ-033 Repeat FETCH pc=0x05 after DECODE -> FETCHED 1 cycle later, instruction 0x1234, no mem_read_valid, hit_count=1.
REQ-034 Fill pc=0x05, then FETCH pc=0x09 (same index, different tag, data 0xBEEF) -> miss, line replaced; FETCH pc=0x05 again -> miss.
REQ-035 flush pulsed coincident with mem_read_ready on pc=0x02 (data 0x00AA) -> instruction 0x00AA delivered; next FETCH pc=0x02 -> miss.
REQ-036 reset_n low 2 cycles during FETCHING -> fetcher_state=IDLE, mem_read_valid=0 immediately (before next clk edge), counters 0.
REQ-037 Force miss_count to 16'hFFFE, two more misses -> miss_count=16'hFFFF, holds.
